// File: rtl/uart_tx_fifo_pkg.sv
// Shared UART TX definitions: FSM state encoding and the default inter-byte gap.
package uart_tx_fifo_pkg;

  localparam int GAP_CYCLES_DEFAULT = 2;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_STROBE = 2'd1;
  localparam logic [1:0] ST_GAP    = 2'd2;

endpackage

// File: rtl/uart_byte_fifo.sv
// Circular byte FIFO with a separately tracked level and registered full/empty flags.
module uart_byte_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [7:0]            din,
  input  logic                  pop,
  input  logic                  flush,
  output logic [7:0]            dout,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   level
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] LVL_FULL = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  do_push;
  logic                  do_pop;
  logic [DEPTH_LOG2:0]   level_nxt;

  // flush wins over everything; a push while full never touches memory
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;
  assign dout    = mem[rd_ptr];

  always_comb begin
    level_nxt = level;
    if (do_push && !do_pop)
      level_nxt = level + 1'b1;
    else if (do_pop && !do_push)
      level_nxt = level - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      level <= level_nxt;
      empty <= (level_nxt == '0);
      full  <= (level_nxt == LVL_FULL);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmit front end: byte FIFO feeding a strobe/gap handshake to a serializer.
//   state  | meaning
//   IDLE   | waiting for a queued byte
//   STROBE | tx_wstrb high, tx_din held until tx_ready
//   GAP    | tx_wstrb low, counting down the inter-byte gap
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4,
  parameter int GAP_CYCLES = GAP_CYCLES_DEFAULT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en,
  input  logic [7:0]          wr_data,
  input  logic                flush,
  input  logic                ovf_clr,
  output logic                full,
  output logic                empty,
  output logic [DEPTH_LOG2:0] level,
  output logic                overflow,
  output logic                busy,
  output logic                tx_wstrb,
  output logic [7:0]          tx_din,
  input  logic                tx_ready
);

  localparam logic [3:0] GAP_LOAD = 4'(GAP_CYCLES - 1);

  logic [1:0] state;
  logic [3:0] gap_cnt;
  logic [7:0] fifo_dout;
  logic       fifo_pop;
  logic       drop;

  assign drop     = wr_en & full & ~flush;
  assign fifo_pop = (state == ST_IDLE) & ~empty & ~flush;
  assign busy     = (state != ST_IDLE);

  uart_byte_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (wr_en),
    .din   (wr_data),
    .pop   (fifo_pop),
    .flush (flush),
    .dout  (fifo_dout),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  // a drop in the same cycle as ovf_clr must leave the flag set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      overflow <= 1'b0;
    else if (drop)
      overflow <= 1'b1;
    else if (ovf_clr)
      overflow <= 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      tx_wstrb <= 1'b0;
      tx_din   <= 8'h00;
      gap_cnt  <= 4'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (fifo_pop) begin
            tx_din   <= fifo_dout;
            tx_wstrb <= 1'b1;
            state    <= ST_STROBE;
          end
        end
        ST_STROBE: begin
          if (tx_ready) begin
            tx_wstrb <= 1'b0;
            gap_cnt  <= GAP_LOAD;
            state    <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (gap_cnt == 4'd0)
            state <= ST_IDLE;
          else
            gap_cnt <= gap_cnt - 1'b1;
        end
        default: begin
          tx_wstrb <= 1'b0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: vector table, directed corner sequences, random run vs. a queue model.
module tb_uart_tx_fifo;

  localparam int DL    = 4;
  localparam int DEPTH = 16;
  localparam int G     = 2;

  logic        clk;
  logic        rst_n;
  logic        wr_en;
  logic [7:0]  wr_data;
  logic        flush;
  logic        ovf_clr;
  logic        full;
  logic        empty;
  logic [DL:0] level;
  logic        overflow;
  logic        busy;
  logic        tx_wstrb;
  logic [7:0]  tx_din;
  logic        tx_ready;

  uart_tx_fifo #(.DEPTH_LOG2(DL), .GAP_CYCLES(G)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .flush    (flush),
    .ovf_clr  (ovf_clr),
    .full     (full),
    .empty    (empty),
    .level    (level),
    .overflow (overflow),
    .busy     (busy),
    .tx_wstrb (tx_wstrb),
    .tx_din   (tx_din),
    .tx_ready (tx_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // reference model: queue contents plus "strobing" and cycles since the last accepted tx_ready
  logic [7:0] q[$];
  logic       m_ovf;
  logic       m_strobing;
  int         m_since;
  logic [7:0] m_din;

  // bookkeeping for emitted bytes and spacing
  int         cyc;
  int         last_rdy_cyc;
  int         spacing_n;
  int         spacing_bad;
  int         rises;
  int         hc;
  logic [7:0] got[$];

  typedef struct {
    logic       we;
    logic [7:0] wd;
    logic       fl;
    logic       oc;
    logic       rdy;
    logic [4:0] lvl;
    logic       ful;
    logic       emp;
    logic       ovf;
    logic       bsy;
    logic       stb;
    logic [7:0] din;
  } vec_t;

  vec_t tbl[11];

  function automatic void model_reset();
    q.delete();
    m_ovf      = 1'b0;
    m_strobing = 1'b0;
    m_since    = 1000;
    m_din      = 8'h00;
  endfunction

  function automatic void model_edge(input logic we, input logic [7:0] wd,
                                     input logic fl, input logic oc, input logic rdy);
    logic full_before;
    logic drop;
    full_before = (q.size() == DEPTH);
    if (m_strobing) begin
      if (rdy) begin
        m_strobing = 1'b0;
        m_since    = 0;
      end
    end else begin
      if (m_since < 1000) m_since++;
      if (m_since > G && q.size() > 0 && !fl) begin
        m_din      = q.pop_front();
        m_strobing = 1'b1;
      end
    end
    drop = we && !fl && full_before;
    if (fl)
      q.delete();
    else if (we && !full_before)
      q.push_back(wd);
    if (drop)
      m_ovf = 1'b1;
    else if (oc)
      m_ovf = 1'b0;
  endfunction

  function automatic logic [14:0] model_vec();
    logic [4:0] lv;
    logic       mb;
    lv = 5'(q.size());
    mb = m_strobing || (m_since < G);
    return {lv, q.size() == DEPTH, q.size() == 0, m_ovf, mb, m_strobing, m_din};
  endfunction

  function automatic logic [14:0] dut_vec();
    return {level, full, empty, overflow, busy, tx_wstrb, tx_din};
  endfunction

  task automatic check_outputs(input string name);
    logic [14:0] exp;
    logic [14:0] act;
    exp = model_vec();
    act = dut_vec();
    n_total++;
    if (act === exp)
      n_pass++;
    else
      $display("FAIL %s cyc=%0d: got {lvl,full,empty,ovf,busy,wstrb,din}=%h required %h",
               name, cyc, act, exp);
  endtask

  task automatic check1(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp)
      n_pass++;
    else
      $display("FAIL %s: got %0h required %0h", name, act, exp);
  endtask

  task automatic step(input logic we, input logic [7:0] wd, input logic fl,
                      input logic oc, input logic rdy, input string name);
    logic prev;
    wr_en    = we;
    wr_data  = wd;
    flush    = fl;
    ovf_clr  = oc;
    tx_ready = rdy;
    prev     = tx_wstrb;
    @(posedge clk);
    if (rdy && m_strobing) last_rdy_cyc = cyc;
    model_edge(we, wd, fl, oc, rdy);
    #1;
    check_outputs(name);
    if (!prev && tx_wstrb) begin
      rises++;
      got.push_back(tx_din);
      if (last_rdy_cyc >= 0) begin
        spacing_n++;
        if (cyc - last_rdy_cyc != G + 1) spacing_bad++;
      end
    end
    cyc++;
  endtask

  task automatic idle(input int n, input string name);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, name);
  endtask

  // serializer model: pulses tx_ready 'delay' cycles after the strobe rises
  task automatic serve(input int ncyc, input int delay, input string name);
    logic rdy;
    hc = 0;
    for (int i = 0; i < ncyc; i++) begin
      rdy = 1'b0;
      if (m_strobing) begin
        hc++;
        if (hc >= delay) begin
          rdy = 1'b1;
          hc  = 0;
        end
      end else begin
        hc = 0;
      end
      step(1'b0, 8'h00, 1'b0, 1'b0, rdy, name);
    end
  endtask

  task automatic clear_track();
    got.delete();
    rises        = 0;
    spacing_n    = 0;
    spacing_bad  = 0;
    last_rdy_cyc = -1;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    wr_en    = 1'b0;
    wr_data  = 8'h00;
    flush    = 1'b0;
    ovf_clr  = 1'b0;
    tx_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset_state");
    @(negedge clk);
    rst_n = 1'b1;
    clear_track();
  endtask

  initial begin
    // {we, wd, fl, oc, rdy, lvl, full, empty, ovf, busy, wstrb, din}
    tbl[0]  = '{1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[1]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h55};
    tbl[2]  = '{1'b1, 8'hA1, 1'b0, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h55};
    tbl[3]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 5'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h55};
    tbl[4]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 5'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h55};
    tbl[5]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h55};
    tbl[6]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA1};
    tbl[7]  = '{1'b1, 8'h77, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA1};
    tbl[8]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'hA1};
    tbl[9]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'hA1};
    tbl[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA1};

    cyc = 0;
    clear_track();
    do_reset();

    for (int i = 0; i < 11; i++) begin
      logic [14:0] exp;
      logic [14:0] act;
      wr_en    = tbl[i].we;
      wr_data  = tbl[i].wd;
      flush    = tbl[i].fl;
      ovf_clr  = tbl[i].oc;
      tx_ready = tbl[i].rdy;
      @(posedge clk);
      model_edge(tbl[i].we, tbl[i].wd, tbl[i].fl, tbl[i].oc, tbl[i].rdy);
      #1;
      exp = {tbl[i].lvl, tbl[i].ful, tbl[i].emp, tbl[i].ovf, tbl[i].bsy, tbl[i].stb, tbl[i].din};
      act = dut_vec();
      n_total++;
      if (act === exp)
        n_pass++;
      else
        $display("FAIL vec[%0d]: got %h required %h", i, act, exp);
      cyc++;
    end

    // single byte with slow serializer
    do_reset();
    step(1'b1, 8'h55, 1'b0, 1'b0, 1'b0, "r34_push");
    check1("r34_not_yet", tx_wstrb, 1'b0);
    idle(1, "r34_wait");
    check1("r34_strobe_latency", tx_wstrb, 1'b1);
    idle(10, "r34_hold");
    check1("r34_hold_wstrb", tx_wstrb, 1'b1);
    check1("r34_hold_din", tx_din, 8'h55);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, "r34_ready");
    check1("r34_wstrb_low", tx_wstrb, 1'b0);
    check1("r34_empty", empty, 1'b1);
    idle(6, "r34_after");

    // fill to full while a byte is held in STROBE, then drop/overflow handling
    do_reset();
    step(1'b1, 8'h00, 1'b0, 1'b0, 1'b0, "r35_first");
    for (int i = 1; i <= 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0, "r35_fill");
    check1("r35_full", full, 1'b1);
    check1("r35_level", level, 5'd16);
    check1("r35_no_ovf", overflow, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, "r36_ready");
    idle(G, "r36_gap");
    step(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0, "r36_drop_with_pop");
    check1("r36_ovf_set", overflow, 1'b1);
    check1("r36_level", level, 5'd15);
    check1("r36_popped", tx_din, 8'h01);
    step(1'b1, 8'hBB, 1'b0, 1'b0, 1'b0, "r36_refill");
    step(1'b1, 8'h99, 1'b0, 1'b1, 1'b0, "r36_clr_and_drop");
    check1("r36_ovf_kept", overflow, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, "r36_clr");
    check1("r36_ovf_cleared", overflow, 1'b0);
    clear_track();
    serve(200, 3, "r35_drain");
    check1("r35_count", got.size(), 16);
    for (int i = 0; i < 16 && i < got.size(); i++)
      check1($sformatf("r35_order[%0d]", i), got[i], (i < 15) ? 8'(i + 2) : 8'hBB);
    check1("r35_spacing_n", spacing_n, 16);
    check1("r35_spacing_bad", spacing_bad, 0);

    // flush while STROBE
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 8'hC1 + 8'(i), 1'b0, 1'b0, 1'b0, "r37_queue");
    check1("r37_level_pre", level, 5'd3);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, "r37_flush");
    check1("r37_level0", level, 5'd0);
    check1("r37_inflight", tx_wstrb, 1'b1);
    clear_track();
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, "r37_ready");
    idle(10, "r37_quiet");
    check1("r37_no_strobes", rises, 0);

    // asynchronous reset mid-STROBE
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 8'hD1 + 8'(i), 1'b0, 1'b0, 1'b0, "r38_queue");
    check1("r38_strobing", tx_wstrb, 1'b1);
    #3;
    rst_n = 1'b0;
    #1;
    check1("r38_wstrb", tx_wstrb, 1'b0);
    check1("r38_empty", empty, 1'b1);
    check1("r38_busy", busy, 1'b0);
    check1("r38_level", level, 5'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    clear_track();
    idle(8, "r38_quiet");
    check1("r38_no_strobes", rises, 0);
    step(1'b1, 8'hE5, 1'b0, 1'b0, 1'b0, "r38_new_push");
    idle(1, "r38_new_strobe");
    check1("r38_new_din", tx_din, 8'hE5);

    // tx_ready ignored in IDLE
    do_reset();
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, "r39_idle_ready");
    check1("r39_idle_busy", busy, 1'b0);

    // random traffic against the model
    do_reset();
    for (int i = 0; i < 800; i++) begin
      logic       we;
      logic [7:0] wd;
      logic       fl;
      logic       oc;
      logic       rdy;
      we  = 1'($urandom_range(0, 1));
      wd  = 8'($urandom);
      fl  = ($urandom_range(0, 63) == 0);
      oc  = ($urandom_range(0, 15) == 0);
      rdy = ($urandom_range(0, 3) == 0);
      step(we, wd, fl, oc, rdy, "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 The module SHALL have parameter DEPTH_LOG2, default 4, giving FIFO depth 2**DEPTH_LOG2 bytes.
REQ-002 The module SHALL have parameter GAP_CYCLES, default 2, the minimum number of cycles tx_wstrb is held low between bytes (legal range 2..15).
REQ-003 Port clk  in  1  single clock; all logic on rising edge.
REQ-004 Port rst_n  in  1  reset, asynchronous, active-low.
REQ-005 Port wr_en  in  1  push wr_data this cycle.
REQ-006 Port wr_data  in  8  byte to transmit.
REQ-007 Port flush  in  1  discard all queued bytes.
REQ-008 Port ovf_clr  in  1  clear the overflow flag.
REQ-009 Port full  out  1  FIFO holds 2**DEPTH_LOG2 bytes.
REQ-010 Port empty  out  1  FIFO holds 0 bytes.
REQ-011 Port level  out  DEPTH_LOG2+1  current byte count.
REQ-012 Port overflow  out  1  sticky: a push was dropped.
REQ-013 Port busy  out  1  FSM not in IDLE.
REQ-014 Port tx_wstrb  out  1  rising-edge strobe to the downstream serializer.
REQ-015 Port tx_din  out  8  byte for the serializer, stable while tx_wstrb high.
REQ-016 Port tx_ready  in  1  single-cycle done pulse from the serializer.

Function
REQ-017 FIFO SHALL be circular, with pointers of DEPTH_LOG2 bits wrapping at 2**DEPTH_LOG2 and level tracked separately; full/empty/level SHALL be registered and valid on the cycle after the change.
REQ-018 A push with full=1 SHALL be dropped and SHALL set overflow, even if a pop occurs in the same cycle.
REQ-019 A simultaneous push (not full) and pop SHALL leave level unchanged.
REQ-020 ovf_clr SHALL clear overflow; if a drop coincides with ovf_clr, overflow SHALL end set.
REQ-021 The FSM SHALL have states IDLE, STROBE and GAP.
REQ-022 IDLE: when empty=0 and flush=0, the FSM SHALL pop the head into tx_din, set tx_wstrb=1 and go to STROBE.
REQ-023 STROBE: tx_wstrb and tx_din SHALL be held; on tx_ready=1 the FSM SHALL clear tx_wstrb, load the gap counter with GAP_CYCLES-1 and go to GAP.
REQ-024 GAP: tx_wstrb SHALL stay 0; the counter SHALL decrement each cycle and at 0 the FSM SHALL go to IDLE.
REQ-025 tx_ready SHALL be ignored in IDLE and GAP.
REQ-026 Latency: with an empty FIFO and FSM in IDLE, tx_wstrb SHALL rise on the second rising edge after the edge that samples wr_en.
REQ-027 Back-to-back bytes: from tx_ready sampled, the next tx_wstrb SHALL rise exactly GAP_CYCLES+1 edges later if the FIFO is non-empty.
REQ-028 flush SHALL zero the pointers and level on the next edge; the in-flight byte (STROBE/GAP) SHALL complete normally; a push coinciding with flush SHALL be discarded without setting overflow.
REQ-029 busy SHALL equal (state != IDLE).

Reset
REQ-030 On rst_n=0, asynchronously: state=IDLE, pointers=0, level=0, empty=1, full=0, overflow=0, busy=0, tx_wstrb=0, tx_din=8'h00, gap counter=0.
REQ-031 Reset mid-transfer SHALL abandon the byte and the queue with no further tx_wstrb edge until new data is pushed after deassertion.

Structure
REQ-032 The FIFO-memory and pointer logic SHALL be one sub-module, uart_byte_fifo; the FSM and overflow flag SHALL be in uart_tx_fifo.
REQ-033 The state encoding and the default GAP_CYCLES SHALL live in the shared UART package; no other typedefs are required.

Verification
REQ-034 Push 8'h55 from reset with the serializer model pulsing tx_ready 11 cycles after the strobe -> tx_wstrb high 2 edges after the push, tx_din=8'h55 held, tx_wstrb low the edge after tx_ready, empty=1.
REQ-035 Push 8'h01..8'h10 (16 bytes) in consecutive cycles -> full=1, level=16, no overflow; bytes emerge in order with a GAP_CYCLES+1 spacing after each tx_ready.
REQ-036 Push a 17th byte while full while the FSM pops the same cycle -> byte dropped, overflow=1; ovf_clr concurrent with a further drop -> overflow stays 1; ovf_clr alone -> 0.
REQ-037 Queue 4 bytes, assert flush while in STROBE -> the current byte completes, level=0 next edge, no further strobes.
REQ-038 Assert rst_n=0 mid-STROBE with 3 bytes queued -> tx_wstrb=0, empty=1 and busy=0 immediately (asynchronous); no strobe follows until a new push.
REQ-039 Inject tx_ready in IDLE and in GAP -> no state change, no pop.
